muldiv_iter_unit: RTL and testbench

//  Iterative signed/unsigned multiply-divide unit that owns the HI/LO result registers.

---
 rtl/muldiv_iter_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_iter_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter_unit.sv
// Iterative signed/unsigned multiply/divide unit owning the HI/LO registers.
// One radix-2 step per clock: shift-add for MULT/MULTU, restoring division for DIV/DIVU.
module muldiv_iter_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // product high half / partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;     // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0] mcand_q, mcand_d; // multiplicand / divisor magnitude
  logic             is_div_q, is_div_d;
  logic             neg_q_q, neg_q_d; // negate product or quotient
  logic             neg_r_q, neg_r_d; // negate remainder
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  // Operand magnitudes and one iteration step of the active operation
  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;

    mul_sum   = {1'b0, rem_q} + {1'b0, (quo_q[0] ? mcand_q : '0)};
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_q};

    if (is_div_q) begin
      step_rem = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      step_rem = mul_sum[WIDTH:1];
      step_quo = {mul_sum[0], quo_q[WIDTH-1:1]};
    end

    prod     = {step_rem, step_quo};
    prod_fix = neg_q_q ? -prod : prod;
    q_fix    = neg_q_q ? -step_quo : step_quo;
    r_fix    = neg_r_q ? -step_rem : step_rem;
  end

  // Next-state, work-register and HI/LO update logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    mcand_d  = mcand_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            if (is_div_q) begin
              hi_d = r_fix;
              lo_d = q_fix;
            end else begin
              hi_d = prod_fix[2*WIDTH-1:WIDTH];
              lo_d = prod_fix[WIDTH-1:0];
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          is_div_d = op[1];
          neg_q_d  = a_neg ^ b_neg;
          neg_r_d  = a_neg;
          mcand_d  = b_mag;
          quo_d    = a_mag;
          rem_d    = '0;
          cnt_d    = CW'(WIDTH);
          if (op[1] && (b == '0)) begin
            state_d = DONE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      mcand_q  <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      mcand_q  <= mcand_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = (state_q == CALC);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed bench for muldiv_iter_unit (WIDTH = 32): vector table plus corner sequences.
module tb_muldiv_iter_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        abort = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_iter_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .abort(abort), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive a start at the next negedge; returns just after E0 (#1)
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Count edges until done is seen (#1 after an edge), bounded
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clock);
      #1 lat++;
    end
  endtask

  initial begin
    int lat, n_done;
    vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC};
    vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{2'b00, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
    vecs[6] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7] = '{2'b11, 32'h00000003, 32'h00000005, 32'h00000003, 32'h00000000};
    vecs[8] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[9] = '{2'b10, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_dz", 64'(div_zero), 64'h0);
    reset = 1'b1;

    // Vector table
    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'h1);
      wait_done(lat);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'd32);
      chk($sformatf("v%0d_busy_done", i), 64'(busy), 64'h0);
      chk($sformatf("v%0d_dz", i), 64'(div_zero), 64'h0);
      chk($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
    end

    // Preload HI/LO, then divide by zero
    @(negedge clock); hi_we = 1'b1; wdata = 32'h11;
    @(negedge clock); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
    @(negedge clock); lo_we = 1'b0;
    chk("pre_hi", 64'(hi), 64'h11);
    chk("pre_lo", 64'(lo), 64'h22);
    launch(2'b11, 32'h7, 32'h0);
    wait_done(lat);
    chk("dz_lat", 64'(lat), 64'd0);
    chk("dz_flag", 64'(div_zero), 64'h1);
    chk("dz_busy", 64'(busy), 64'h0);
    chk("dz_hi", 64'(hi), 64'h11);
    chk("dz_lo", 64'(lo), 64'h22);
    @(posedge clock); #1;
    chk("dz_done_pulse", 64'(done), 64'h0);
    chk("dz_flag_pulse", 64'(div_zero), 64'h0);

    // Start while busy is ignored
    launch(2'b00, 32'd3, 32'd5);
    repeat (4) @(posedge clock);
    @(negedge clock); start = 1'b1; a = 32'd100; b = 32'd100;
    @(posedge clock); #1 start = 1'b0;
    wait_done(lat);
    chk("ign_lat", 64'(lat + 5), 64'd32);
    chk("ign_hi", 64'(hi), 64'h0);
    chk("ign_lo", 64'(lo), 64'hF);

    // Abort at E10, with a HI write attempted during CALC
    launch(2'b00, 32'd9, 32'd9);
    repeat (2) @(posedge clock);
    @(negedge clock); hi_we = 1'b1; wdata = 32'hDEAD;
    @(posedge clock); #1 hi_we = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock); abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'h0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done) n_done++;
    end
    chk("abort_no_done", 64'(n_done), 64'd0);
    chk("abort_hi", 64'(hi), 64'h0);
    chk("abort_lo", 64'(lo), 64'hF);

    // Write and start at the same edge
    @(negedge clock);
    hi_we = 1'b1; wdata = 32'hABC; start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
    @(posedge clock); #1 hi_we = 1'b0; start = 1'b0;
    chk("ws_hi", 64'(hi), 64'hABC);
    chk("ws_busy", 64'(busy), 64'h1);
    wait_done(lat);
    chk("ws_res_hi", 64'(hi), 64'h0);
    chk("ws_res_lo", 64'(lo), 64'h6);

    // Reset held low at E16 of a DIV, then a normal DIV
    launch(2'b10, 32'd100, 32'd7);
    repeat (15) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    #1;
    chk("mrst_hi", 64'(hi), 64'h0);
    chk("mrst_lo", 64'(lo), 64'h0);
    chk("mrst_busy", 64'(busy), 64'h0);
    @(negedge clock); reset = 1'b1;
    launch(2'b10, 32'd100, 32'd7);
    wait_done(lat);
    chk("post_lat", 64'(lat), 64'd32);
    chk("post_hi", 64'(hi), 64'h2);
    chk("post_lo", 64'(lo), 64'hE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
